// File: rtl/handshake_pkg.sv
// Shared types and helpers for the two-slot valid/ready elastic buffer.
package handshake_pkg;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StEmpty = 2'd1,
    StHalf  = 2'd2,
    StFull  = 2'd3
  } state_e;

  function automatic logic fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/handshake_buffer_2slot_if.sv
// Valid/ready channel bundle: upstream side (ins*) and downstream side (outs*) of the buffer.
interface handshake_buffer_2slot_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  // Environment view: produces upstream tokens and consumes downstream ones.
  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  // Buffer view.
  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );

endinterface

// File: rtl/handshake_data_reg.sv
// Data register with load enable and asynchronous active-low clear.
module handshake_data_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/handshake_buffer_2slot.sv
// Two-slot elastic buffer: registers valid, data and ready so no input reaches an output
// combinationally, while still sustaining one token per cycle.
module handshake_buffer_2slot
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                     clk,
  input logic                     rst,
  handshake_buffer_2slot_if.slave bus
);

  state_e r_state, w_state_d;
  logic   r_ins_ready, r_outs_valid;
  logic   w_in_fire, w_out_fire;
  logic   w_load_m, w_load_s, w_m_from_s;

  logic [DATA_WIDTH-1:0] w_m_d, w_m_q, w_s_q;

  assign w_in_fire  = fire(bus.ins_valid, r_ins_ready);
  assign w_out_fire = fire(r_outs_valid, bus.outs_ready);

  always_comb begin
    w_state_d  = r_state;
    w_load_m   = 1'b0;
    w_load_s   = 1'b0;
    w_m_from_s = 1'b0;
    unique case (r_state)
      StInit: w_state_d = StEmpty;
      StEmpty: begin
        if (w_in_fire) begin
          w_load_m  = 1'b1;
          w_state_d = StHalf;
        end
      end
      StHalf: begin
        if (w_in_fire && w_out_fire) begin
          w_load_m = 1'b1;
        end else if (w_in_fire) begin
          w_load_s  = 1'b1;
          w_state_d = StFull;
        end else if (w_out_fire) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        // Skid slot refills the head so arrival order is preserved.
        if (w_out_fire) begin
          w_load_m   = 1'b1;
          w_m_from_s = 1'b1;
          w_state_d  = StHalf;
        end
      end
      default: w_state_d = StInit;
    endcase
  end

  // Handshake outputs are their own flops, derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StInit;
      r_ins_ready  <= 1'b0;
      r_outs_valid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_ins_ready  <= (w_state_d == StEmpty) || (w_state_d == StHalf);
      r_outs_valid <= (w_state_d == StHalf) || (w_state_d == StFull);
    end
  end

  assign w_m_d = w_m_from_s ? w_s_q : bus.ins;

  handshake_data_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_main_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load_m),
    .i_d    (w_m_d),
    .o_q    (w_m_q)
  );

  handshake_data_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load_s),
    .i_d    (bus.ins),
    .o_q    (w_s_q)
  );

  assign bus.ins_ready  = r_ins_ready;
  assign bus.outs_valid = r_outs_valid;
  assign bus.outs       = w_m_q;

endmodule

// File: tb/tb_handshake_buffer_2slot.sv
// Bench for the two-slot buffer: directed steps plus random traffic against a FIFO model.
module tb_handshake_buffer_2slot;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_out;

  logic [31:0] mdl_q[$];
  logic [31:0] mdl_last;
  logic        mdl_init;

  handshake_buffer_2slot_if #(.DATA_WIDTH(32)) bus ();

  handshake_buffer_2slot #(
    .DATA_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    mdl_last = '0;
    mdl_init = 1'b1;
  endtask

  // Capacity-2 FIFO: ready while fewer than two tokens held (after the post-reset cycle),
  // valid while non-empty, outs shows the head or the last departed token.
  task automatic cycle();
    logic        exp_ready, exp_valid, in_f, out_f;
    logic [31:0] exp_outs, data;
    exp_ready = !mdl_init && (mdl_q.size() < 2);
    exp_valid = mdl_q.size() > 0;
    exp_outs  = exp_valid ? mdl_q[0] : mdl_last;
    check("ins_ready", {31'd0, bus.ins_ready}, {31'd0, exp_ready});
    check("outs_valid", {31'd0, bus.outs_valid}, {31'd0, exp_valid});
    check("outs", bus.outs, exp_outs);
    in_f  = bus.ins_valid && exp_ready;
    out_f = exp_valid && bus.outs_ready;
    data  = bus.ins;
    @(posedge clk);
    mdl_init = 1'b0;
    if (out_f) begin
      mdl_last = mdl_q.pop_front();
      n_out++;
    end
    if (in_f) mdl_q.push_back(data);
    #1;
  endtask

  initial begin
    int n_start;
    n_checks = 0;
    n_fail   = 0;
    n_out    = 0;
    model_reset();

    // Reset with the channel active on both sides.
    rst            = 1'b0;
    bus.ins        = 32'h000A_7C98;
    bus.ins_valid  = 1'b1;
    bus.outs_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs_valid", {31'd0, bus.outs_valid}, 32'd0);
    check("rst_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
    check("rst_outs", bus.outs, 32'd0);
    rst = 1'b1;
    cycle();  // INIT: not yet ready
    cycle();  // ready now, token accepted
    bus.ins_valid = 1'b0;
    check("first_token", bus.outs, 32'h000A_7C98);
    check("first_valid", {31'd0, bus.outs_valid}, 32'd1);
    cycle();
    repeat (2) cycle();

    // Streaming at full rate.
    n_start = n_out;
    bus.outs_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      bus.ins       = i;
      bus.ins_valid = 1'b1;
      check("stream_ready", {31'd0, bus.ins_ready}, 32'd1);
      cycle();
    end
    bus.ins_valid = 1'b0;
    cycle();
    check("stream_count", n_out - n_start, 32'd100);
    cycle();

    // Backpressure: two slots fill, third token waits.
    bus.outs_ready = 1'b0;
    bus.ins_valid  = 1'b1;
    bus.ins        = 32'hAA;
    cycle();
    bus.ins = 32'hBB;
    cycle();
    bus.ins = 32'hCC;
    repeat (3) begin
      cycle();
      check("bp_ready", {31'd0, bus.ins_ready}, 32'd0);
      check("bp_outs", bus.outs, 32'hAA);
    end
    bus.outs_ready = 1'b1;
    cycle();
    check("bp_order1", bus.outs, 32'hBB);
    cycle();
    bus.ins_valid = 1'b0;
    check("bp_order2", bus.outs, 32'hCC);
    cycle();
    cycle();

    // Simultaneous fire in HALF.
    bus.ins_valid = 1'b1;
    bus.ins       = 32'h11;
    cycle();
    bus.ins = 32'h22;
    cycle();
    check("sim_outs", bus.outs, 32'h22);
    check("sim_ready", {31'd0, bus.ins_ready}, 32'd1);
    check("sim_valid", {31'd0, bus.outs_valid}, 32'd1);
    bus.ins_valid = 1'b0;
    cycle();
    cycle();

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      bus.ins        = $urandom;
      bus.ins_valid  = ($urandom_range(0, 3) != 0);
      bus.outs_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Asynchronous reset while FULL.
    bus.ins_valid  = 1'b0;
    bus.outs_ready = 1'b1;
    repeat (3) cycle();
    bus.outs_ready = 1'b0;
    bus.ins_valid  = 1'b1;
    bus.ins        = 32'hDEAD_0001;
    cycle();
    bus.ins = 32'hDEAD_0002;
    cycle();
    check("full_ready", {31'd0, bus.ins_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("async_valid", {31'd0, bus.outs_valid}, 32'd0);
    check("async_outs", bus.outs, 32'd0);
    check("async_ready", {31'd0, bus.ins_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    bus.ins_valid  = 1'b0;
    bus.outs_ready = 1'b1;
    repeat (4) cycle();
    bus.ins_valid = 1'b1;
    bus.ins       = 32'h5A5A_5A5A;
    cycle();
    bus.ins_valid = 1'b0;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_buffer_2slot.md
# handshake_buffer_2slot

Two-slot elastic buffer that registers a valid/ready channel and breaks both the forward path (`valid`, data) and the backward path (`ready`). It sits directly downstream of constant generators and other combinational handshake producers, which pass `ctrl_valid` and `outs_ready` straight through. It cuts the resulting combinational valid/ready chains at full throughput (one token per cycle) with one cycle of forward latency.

## Interface
- `DATA_WIDTH`, 32, width of the data token.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `ins`  in  DATA_WIDTH  upstream data token.
- `ins_valid`  in  1  upstream token valid.
- `ins_ready`  out  1  buffer can accept; driven directly from a flop.
- `outs`  out  DATA_WIDTH  downstream data; driven directly from the main data register.
- `outs_valid`  out  1  downstream token valid; driven directly from a flop.
- `outs_ready`  in  1  downstream accepts.

## Operation
- Transfer rule:
  - input fire = `ins_valid & ins_ready`.
  - output fire = `outs_valid & outs_ready`.
- Storage: main register M (drives `outs`) and skid register S.
- States:
  - INIT: after reset; `ins_ready`=0, `outs_valid`=0.
  - EMPTY: `ins_ready`=1, `outs_valid`=0.
  - HALF: M holds a token; `ins_ready`=1, `outs_valid`=1.
  - FULL: M and S hold tokens; `ins_ready`=0, `outs_valid`=1.
- Transitions:
  - INIT→EMPTY unconditionally on the first edge after reset release.
  - EMPTY: input fire → M←`ins`, go to HALF. No output fire is possible in EMPTY.
  - HALF, input fire and output fire → M←`ins`, stay HALF.
  - HALF, input fire only → S←`ins`, go to FULL.
  - HALF, output fire only → go to EMPTY.
  - HALF, neither → hold.
  - FULL: output fire → M←S, go to HALF. No input fire is possible in FULL. Otherwise hold.
- Ordering: tokens leave in strict arrival order; none dropped or duplicated.
- `ins` is ignored when there is no input fire. `outs` holds its last value in EMPTY; it is not cleared.
- Reset mid-operation: both tokens are discarded immediately and asynchronously. Outputs take their reset values while `rst`=0.

## Timing
- Reset values: `outs_valid`=0, `ins_ready`=0, `outs`=0, S=0, state INIT.
- `ins_ready` goes to 1 one edge after `rst` rises.
- Latency: a token accepted at edge n is on `outs` with `outs_valid`=1 in the cycle after edge n.
- Throughput: one token per cycle with `outs_ready` held at 1.
- No combinational path from any input to any output.
- `ins_ready` deasserts in the cycle after the second token is held while the output is stalled. Capacity is therefore exactly 2.
- Stall behaviour: while `outs_valid`=1 and `outs_ready`=0, `outs` is stable. Upstream may change `ins` freely while `ins_ready`=0.

## Structure
- A shared package `handshake_pkg` holds:
  - the 2-bit state enum (INIT=0, EMPTY=1, HALF=2, FULL=3);
  - the helper function `fire(valid, ready)`.
- `ins_ready` and `outs_valid` are separate flops computed from the next state, not decoded from the state register.
- One sub-module is natural: `handshake_data_reg`, a DATA_WIDTH register with load-enable and asynchronous active-low clear. It is instantiated twice, once for M and once for S.

## Test plan
- Reset and INIT:
  - Stimulus: hold `rst`=0 with `ins_valid`=1, `outs_ready`=1.
  - Response: `outs_valid`=0, `ins_ready`=0, `outs`=0. `ins_ready`=1 exactly one edge after `rst` rises; a token 0x0A7C98 then appears on `outs` the following cycle.
- Streaming:
  - Stimulus: `outs_ready`=1, tokens 1..100 back-to-back.
  - Response: 100 tokens out in order on 100 consecutive cycles; `ins_ready` stays at 1 throughout.
- Backpressure:
  - Stimulus: `outs_ready`=0, present 0xAA, 0xBB, 0xCC.
  - Response: 0xAA and 0xBB accepted; `ins_ready`=0 and 0xCC waits; `outs` stays 0xAA. After `outs_ready`=1 the output order is 0xAA, 0xBB, 0xCC.
- Simultaneous fire in HALF:
  - Stimulus: while HALF, input and output fire on the same edge.
  - Response: state stays HALF and `outs` updates to the new token.
- Random valid/ready (10k cycles) against a scoreboard:
  - Response: no loss, duplication or reordering; `outs` stable whenever a transfer is stalled.
- Mid-operation reset:
  - Stimulus: assert `rst`=0 asynchronously (between edges) while FULL.
  - Response: `outs_valid`=0 and `outs`=0 without waiting for a clock edge. After release, neither old token reappears.
